f2h_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter and sequencer feeding the FPGA-to-HPS packet FIFO's Avalon-MM write slave. Accepts up to NREQ Avalon-ST packet sources and serialises whole packets into the FIFO, with no interleaving between packets. For each beat that carries start- or end-of-packet, it writes the FIFO's control register (address 1) first, then the data register (address 0). Data is pre-byte-swapped so the FIFO's stream output reproduces source byte order.

---
 rtl/f2h_pkt_pkg.sv | 39 +++
 rtl/f2h_packet_arbiter_rr.sv | 33 +++
 rtl/f2h_packet_arbiter.sv | 156 +++++++++++++++
 tb/tb_f2h_packet_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f2h_pkt_pkg.sv
// Shared types, control-word layout and helpers for the
// FPGA-to-HPS packet arbiter.
package f2h_pkt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CTRL = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam int SOP_BIT   = 0;
    localparam int EOP_BIT   = 1;
    localparam int EMPTY_LSB = 2;
    localparam int EMPTY_MSB = 3;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    // FIFO emits the word MSB-first, so swap to keep source byte order
    function automatic logic [31:0] byteswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] ctrl_word(
        input logic       sop,
        input logic       eop,
        input logic [1:0] empty
    );
        logic [31:0] w;
        w = '0;
        w[SOP_BIT] = sop;
        w[EOP_BIT] = eop;
        if (eop) begin
            w[EMPTY_MSB:EMPTY_LSB] = empty;
        end
        return w;
    endfunction

endpackage

// File: rtl/f2h_packet_arbiter_rr.sv
// Combinational round-robin picker: search starts one past
// the last served source and wraps around.
module pkt_rr_arbiter
    import f2h_pkt_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/f2h_packet_arbiter.sv
// Packet-level round-robin sequencer from NREQ Avalon-ST sources
// into the F2H FIFO's Avalon-MM control/data write slave.
module f2h_packet_arbiter
    import f2h_pkt_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ*32-1:0] snk_data,
    input  logic [NREQ-1:0]   snk_valid,
    input  logic [NREQ-1:0]   snk_sop,
    input  logic [NREQ-1:0]   snk_eop,
    input  logic [NREQ*2-1:0] snk_empty,
    output logic [NREQ-1:0]   snk_ready,
    output logic              avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic [NREQ-1:0]   grant,
    output logic              pkt_done,
    output logic              proto_err
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   last;
    logic            ctrl_done;
    logic            first;

    logic [IW-1:0]   gidx;
    logic [31:0]     g_data;
    logic            g_valid;
    logic            g_sop;
    logic            g_eop;
    logic [1:0]      g_empty;

    logic [NREQ-1:0] winner;
    logic            any;
    logic [NREQ-1:0] drop;
    logic            to_ctrl;
    logic            accept;

    pkt_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req    (snk_valid & snk_sop),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                gidx = IW'(i);
            end
        end
    end

    assign g_data  = snk_data[int'(gidx)*32 +: 32];
    assign g_valid = snk_valid[gidx];
    assign g_sop   = snk_sop[gidx];
    assign g_eop   = snk_eop[gidx];
    assign g_empty = snk_empty[int'(gidx)*2 +: 2];
    assign drop    = snk_valid & ~snk_sop;
    assign grant   = grant_q;

    // Command follows the held source beat, so it stays stable under waitrequest
    always_comb begin
        avm_address   = ADDR_DATA;
        avm_write     = 1'b0;
        avm_writedata = '0;
        snk_ready     = '0;
        pkt_done      = 1'b0;
        proto_err     = 1'b0;
        to_ctrl       = 1'b0;
        accept        = 1'b0;
        if (!reset) begin
            unique case (state)
                S_IDLE: begin
                    snk_ready = drop;
                    proto_err = |drop;
                end
                S_CTRL: begin
                    avm_address   = ADDR_CTRL;
                    avm_write     = 1'b1;
                    avm_writedata = ctrl_word(g_sop, g_eop, g_empty);
                end
                S_DATA: begin
                    avm_writedata = byteswap32(g_data);
                    if (g_valid && !ctrl_done &&
                        (g_eop || (g_sop && first))) begin
                        to_ctrl = 1'b1;
                    end else begin
                        avm_write       = g_valid;
                        snk_ready[gidx] = !avm_waitrequest;
                        accept          = g_valid && !avm_waitrequest;
                        pkt_done        = accept && g_eop;
                        proto_err       = accept && g_sop && !first;
                    end
                end
                default: begin
                    avm_write = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            grant_q   <= '0;
            last      <= IW'(NREQ - 1);
            ctrl_done <= 1'b0;
            first     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any) begin
                        grant_q <= winner;
                        first   <= 1'b1;
                        state   <= S_CTRL;
                    end
                end
                S_CTRL: begin
                    if (!avm_waitrequest) begin
                        ctrl_done <= 1'b1;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (to_ctrl) begin
                        state <= S_CTRL;
                    end else if (accept) begin
                        ctrl_done <= 1'b0;
                        first     <= 1'b0;
                        if (g_eop) begin
                            last    <= gidx;
                            grant_q <= '0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f2h_packet_arbiter.sv
// Directed bench for f2h_packet_arbiter with two queued
// Avalon-ST sources and a write log of the Avalon-MM side.
module tb_f2h_packet_arbiter;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  e;
    } beat_t;

    logic        clock;
    logic        reset;
    logic [63:0] snk_data;
    logic [1:0]  snk_valid;
    logic [1:0]  snk_sop;
    logic [1:0]  snk_eop;
    logic [3:0]  snk_empty;
    logic [1:0]  snk_ready;
    logic        avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [1:0]  grant;
    logic        pkt_done;
    logic        proto_err;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [1:0]  gate;
    logic [32:0] wlog[$];
    int          n_done;
    int          n_err;
    int          pops0;
    int          total;
    int          bad;

    f2h_packet_arbiter #(.NREQ(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_sop         (snk_sop),
        .snk_eop         (snk_eop),
        .snk_empty       (snk_empty),
        .snk_ready       (snk_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .grant           (grant),
        .pkt_done        (pkt_done),
        .proto_err       (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic beat_t mk(logic [31:0] d, logic s,
                                 logic e, logic [1:0] em);
        beat_t b;
        b.d = d; b.sop = s; b.eop = e; b.e = em;
        return b;
    endfunction

    task automatic drive();
        snk_valid = '0; snk_sop = '0; snk_eop = '0;
        snk_data = '0; snk_empty = '0;
        if (gate[0] && q0.size() > 0) begin
            snk_valid[0] = 1'b1;
            snk_data[31:0] = q0[0].d;
            snk_sop[0] = q0[0].sop;
            snk_eop[0] = q0[0].eop;
            snk_empty[1:0] = q0[0].e;
        end
        if (gate[1] && q1.size() > 0) begin
            snk_valid[1] = 1'b1;
            snk_data[63:32] = q1[0].d;
            snk_sop[1] = q1[0].sop;
            snk_eop[1] = q1[0].eop;
            snk_empty[3:2] = q1[0].e;
        end
    endtask

    // Sample before the edge, then pop accepted beats and re-drive
    task automatic tick();
        logic [1:0] acc;
        #2;
        acc = snk_valid & snk_ready;
        if (avm_write && !avm_waitrequest)
            wlog.push_back({avm_address, avm_writedata});
        if (pkt_done) n_done++;
        if (proto_err) n_err++;
        @(posedge clock);
        #1;
        if (acc[0]) begin void'(q0.pop_front()); pops0++; end
        if (acc[1]) void'(q1.pop_front());
        drive();
        #1;
    endtask

    task automatic drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (q0.size() == 0 && q1.size() == 0 &&
                grant == 2'b00 && !avm_write) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({avm_write, avm_address, avm_writedata, snk_ready,
             pkt_done, proto_err, grant} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got w=%b a=%b d=%h r=%b g=%b",
                     avm_write, avm_address, avm_writedata,
                     snk_ready, grant);
        end
        reset = 1'b0;
        tick();
        total++;
        if (grant !== 2'b00 || avm_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got g=%b w=%b want 00 0",
                     grant, avm_write);
        end
    endtask

    task automatic test_single_beat();
        logic [32:0] e[2];
        bit ok;
        e[0] = {1'b1, 32'h0000000B};
        e[1] = {1'b0, 32'h44332211};
        wlog.delete(); n_done = 0;
        q0.push_back(mk(32'h11223344, 1, 1, 2'd2));
        drive(); #1;
        drain(50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout"); end
        total++;
        if (wlog.size() != 2) begin
            bad++;
            $display("FAIL single_count got %0d want 2", wlog.size());
        end
        for (int k = 0; k < 2 && k < wlog.size(); k++) begin
            total++;
            if (wlog[k] !== e[k]) begin
                bad++;
                $display("FAIL single_wr%0d got %h want %h", k, wlog[k], e[k]);
            end
        end
        total++;
        if (n_done != 1 || grant !== 2'b00) begin
            bad++;
            $display("FAIL single_done got done=%0d g=%b want 1 00",
                     n_done, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [32:0] e[12];
        bit ok;
        e[0]  = {1'b1, 32'h1};
        e[1]  = {1'b0, 32'h04030201};
        e[2]  = {1'b0, 32'h08070605};
        e[3]  = {1'b1, 32'h2};
        e[4]  = {1'b0, 32'h0C0B0A09};
        e[5]  = {1'b1, 32'h1};
        e[6]  = {1'b0, 32'h14131211};
        e[7]  = {1'b0, 32'h18171615};
        e[8]  = {1'b1, 32'h2};
        e[9]  = {1'b0, 32'h1C1B1A19};
        e[10] = {1'b1, 32'h3};
        e[11] = {1'b0, 32'h24232221};
        reset = 1'b1; tick(); reset = 1'b0; tick();
        wlog.delete(); n_done = 0;
        q0.push_back(mk(32'h01020304, 1, 0, 0));
        q0.push_back(mk(32'h05060708, 0, 0, 0));
        q0.push_back(mk(32'h090A0B0C, 0, 1, 0));
        q0.push_back(mk(32'h21222324, 1, 1, 0));
        q1.push_back(mk(32'h11121314, 1, 0, 0));
        q1.push_back(mk(32'h15161718, 0, 0, 0));
        q1.push_back(mk(32'h191A1B1C, 0, 1, 0));
        drive(); #1;
        drain(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_timeout"); end
        total++;
        if (wlog.size() != 12) begin
            bad++;
            $display("FAIL rr_count got %0d want 12", wlog.size());
        end
        for (int k = 0; k < 12 && k < wlog.size(); k++) begin
            total++;
            if (wlog[k] !== e[k]) begin
                bad++;
                $display("FAIL rr_wr%0d got %h want %h", k, wlog[k], e[k]);
            end
        end
        total++;
        if (n_done != 3) begin
            bad++;
            $display("FAIL rr_done got %0d want 3", n_done);
        end
    endtask

    task automatic test_waitrequest();
        logic [32:0] e[5];
        bit ok;
        e[0] = {1'b1, 32'h1};
        e[1] = {1'b0, 32'hDDCCBBAA};
        e[2] = {1'b0, 32'h78563412};
        e[3] = {1'b1, 32'h6};
        e[4] = {1'b0, 32'h0DF0FECA};
        wlog.delete();
        q1.push_back(mk(32'hAABBCCDD, 1, 0, 0));
        q1.push_back(mk(32'h12345678, 0, 0, 0));
        q1.push_back(mk(32'hCAFEF00D, 0, 1, 2'd1));
        drive(); #1;
        tick();
        avm_waitrequest = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({avm_write, avm_address, avm_writedata, snk_ready}
                !== {1'b1, 1'b1, 32'h1, 2'b00}) begin
                bad++;
                $display("FAIL wait_ctrl%0d got w=%b a=%b d=%h r=%b", i,
                         avm_write, avm_address, avm_writedata, snk_ready);
            end
            tick();
        end
        avm_waitrequest = 1'b0; #1;
        tick();
        tick();
        avm_waitrequest = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({avm_write, avm_address, avm_writedata, snk_ready}
                !== {1'b1, 1'b0, 32'h78563412, 2'b00}) begin
                bad++;
                $display("FAIL wait_data%0d got w=%b a=%b d=%h r=%b", i,
                         avm_write, avm_address, avm_writedata, snk_ready);
            end
            tick();
        end
        avm_waitrequest = 1'b0; #1;
        drain(50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wait_timeout"); end
        total++;
        if (wlog.size() != 5) begin
            bad++;
            $display("FAIL wait_count got %0d want 5", wlog.size());
        end
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            total++;
            if (wlog[k] !== e[k]) begin
                bad++;
                $display("FAIL wait_wr%0d got %h want %h", k, wlog[k], e[k]);
            end
        end
    endtask

    task automatic test_idle_drop();
        wlog.delete(); n_err = 0;
        q1.push_back(mk(32'h00000055, 0, 0, 0));
        drive(); #1;
        total++;
        if ({snk_ready, proto_err, avm_write} !== {2'b10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL drop_now got r=%b e=%b w=%b want 10 1 0",
                     snk_ready, proto_err, avm_write);
        end
        tick();
        tick();
        total++;
        if (n_err != 1 || wlog.size() != 0 || q1.size() != 0 ||
            grant !== 2'b00) begin
            bad++;
            $display("FAIL drop_after got err=%0d wr=%0d q=%0d g=%b",
                     n_err, wlog.size(), q1.size(), grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [32:0] e[4];
        bit ok;
        e[0] = {1'b1, 32'h1};
        e[1] = {1'b0, 32'hEFBEADDE};
        e[2] = {1'b1, 32'hE};
        e[3] = {1'b0, 32'h67452301};
        pops0 = 0;
        q0.push_back(mk(32'hE0E0E0E0, 1, 0, 0));
        q0.push_back(mk(32'hE1E1E1E1, 0, 0, 0));
        q0.push_back(mk(32'hE2E2E2E2, 0, 0, 0));
        q0.push_back(mk(32'hE3E3E3E3, 0, 0, 0));
        q0.push_back(mk(32'hE4E4E4E4, 0, 1, 0));
        drive(); #1;
        for (int i = 0; i < 20 && pops0 < 2; i++) tick();
        total++;
        if (pops0 != 2 || grant !== 2'b01) begin
            bad++;
            $display("FAIL rst_mid_pre got pops=%0d g=%b", pops0, grant);
        end
        reset = 1'b1;
        q0.delete();
        drive(); #1;
        tick();
        total++;
        if ({avm_write, avm_address, avm_writedata, snk_ready,
             pkt_done, proto_err, grant} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got w=%b a=%b d=%h r=%b g=%b",
                     avm_write, avm_address, avm_writedata,
                     snk_ready, grant);
        end
        reset = 1'b0;
        tick();
        wlog.delete();
        q1.push_back(mk(32'hDEADBEEF, 1, 0, 0));
        q1.push_back(mk(32'h01234567, 0, 1, 2'd3));
        drive(); #1;
        drain(50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_timeout"); end
        total++;
        if (wlog.size() != 4) begin
            bad++;
            $display("FAIL rst_mid_count got %0d want 4", wlog.size());
        end
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            total++;
            if (wlog[k] !== e[k]) begin
                bad++;
                $display("FAIL rst_mid_wr%0d got %h want %h", k, wlog[k], e[k]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [32:0] e[7];
        bit ok;
        e[0] = {1'b1, 32'h1};
        e[1] = {1'b0, 32'h40302010};
        e[2] = {1'b0, 32'h80706050};
        e[3] = {1'b1, 32'h2};
        e[4] = {1'b0, 32'hC0B0A090};
        e[5] = {1'b1, 32'h3};
        e[6] = {1'b0, 32'h0C0D0E0F};
        wlog.delete();
        q0.push_back(mk(32'h10203040, 1, 0, 0));
        q0.push_back(mk(32'h50607080, 0, 0, 0));
        q0.push_back(mk(32'h90A0B0C0, 0, 1, 0));
        q1.push_back(mk(32'h0F0E0D0C, 1, 1, 0));
        drive(); #1;
        tick();
        tick();
        total++;
        if (avm_write !== 1'b1 || avm_address !== 1'b0 ||
            grant !== 2'b01) begin
            bad++;
            $display("FAIL gap_v1 got w=%b a=%b g=%b want 1 0 01",
                     avm_write, avm_address, grant);
        end
        tick();
        gate[0] = 1'b0;
        drive(); #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (avm_write !== 1'b0 || grant !== 2'b01) begin
                bad++;
                $display("FAIL gap_v0_%0d got w=%b g=%b want 0 01",
                         i, avm_write, grant);
            end
            tick();
        end
        gate[0] = 1'b1;
        drive(); #1;
        total++;
        if (avm_write !== 1'b1 || grant !== 2'b01) begin
            bad++;
            $display("FAIL gap_v1b got w=%b g=%b want 1 01",
                     avm_write, grant);
        end
        drain(80, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL gap_timeout"); end
        total++;
        if (wlog.size() != 7) begin
            bad++;
            $display("FAIL gap_count got %0d want 7", wlog.size());
        end
        for (int k = 0; k < 7 && k < wlog.size(); k++) begin
            total++;
            if (wlog[k] !== e[k]) begin
                bad++;
                $display("FAIL gap_wr%0d got %h want %h", k, wlog[k], e[k]);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        n_done = 0; n_err = 0; pops0 = 0;
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        gate = 2'b11;
        drive();
        @(posedge clock);
        #1;
        drive();
        #1;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_waitrequest();
        test_idle_drop();
        test_reset_mid_packet();
        test_valid_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
